cam_fill_ctrl: RTL and testbench

- Write-side controller for the cam2 content-addressable memory.
- Accepts insert and invalidate requests over a valid/ready handshake and keeps a shadow valid bitmap.
- Allocates the lowest free slot and drives the CAM write port: write_, w_addr, wdata, new_tag, new_valid.
- Optionally issues a lookup on the CAM read port before inserting, so duplicate tags are rejected.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_fill_ctrl_free_pick.sv | 32 +++
 rtl/cam_fill_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cam_fill_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Brief    : Shared types and default geometry for the cam2 fill controller.
// Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int C_BITS   = 8;
    localparam int C_TAG_SZ = 8;
    localparam int C_WORDS  = 8;

    typedef enum logic {
        CAM_INSERT = 1'b0,
        CAM_INVAL  = 1'b1
    } cam_op_t;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_DUP  = 2'b01,
        ST_FULL = 2'b10
    } cam_status_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/cam_fill_ctrl_free_pick.sv
`default_nettype none
// ============================================================================
// Module   : cam_free_pick
// Brief    : Combinational priority encoder returning the lowest clear bit.
// Revision : 1.0 - initial release
// ============================================================================
module cam_free_pick
    import cam_pkg::*;
#(
    parameter int WORDS = C_WORDS
) (
    input  logic [WORDS-1:0]         bitmap,
    output logic [$clog2(WORDS)-1:0] idx,
    output logic                     none_free
);

    localparam int AW = $clog2(WORDS);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx       = '0;
        none_free = 1'b1;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                idx       = AW'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_fill_ctrl
// Brief    : Write-side controller for cam2: lowest-free-slot insert and
//            invalidate with a shadow valid bitmap.
// Options  : CAM_FILL_DUP_CHECK_EN - look the tag up first, reject duplicates.
// Revision : 1.0 - initial release
// ============================================================================
module cam_fill_ctrl
    import cam_pkg::*;
#(
    parameter int BITS   = C_BITS,
    parameter int TAG_SZ = C_TAG_SZ,
    parameter int WORDS  = C_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [TAG_SZ-1:0]          req_tag,
    input  logic [BITS-1:0]            req_data,
    input  logic [$clog2(WORDS)-1:0]   req_addr,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_status,
    output logic [$clog2(WORDS)-1:0]   rsp_addr,
    output logic                       cam_write_,
    output logic [$clog2(WORDS)-1:0]   cam_w_addr,
    output logic [BITS-1:0]            cam_wdata,
    output logic [TAG_SZ-1:0]          cam_new_tag,
    output logic                       cam_new_valid,
    output logic                       cam_read,
    output logic [TAG_SZ-1:0]          cam_check_tag,
    input  logic                       cam_found_it,
    output logic                       full,
    output logic [$clog2(WORDS+1)-1:0] count
);

    localparam int              AW         = $clog2(WORDS);
    localparam int              CW         = $clog2(WORDS + 1);
    localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   C_CNT_FULL = CW'(WORDS);

    fill_state_t      r_state;
    logic [WORDS-1:0] r_bitmap;
    logic [AW-1:0]    w_free_idx;
    logic             w_none_free;
    logic             w_unused;

`ifdef CAM_FILL_DUP_CHECK_EN
    logic [TAG_SZ-1:0] r_tag;
    logic [BITS-1:0]   r_data;
    assign w_unused = w_none_free;
`else
    assign w_unused = w_none_free ^ cam_found_it;
`endif

    cam_free_pick #(
        .WORDS (WORDS)
    ) u_free_pick (
        .bitmap    (r_bitmap),
        .idx       (w_free_idx),
        .none_free (w_none_free)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state       <= IDLE;
            r_bitmap      <= '0;
            count         <= '0;
            full          <= 1'b0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_status    <= ST_OK;
            rsp_addr      <= '0;
            cam_write_    <= 1'b1;
            cam_w_addr    <= '0;
            cam_wdata     <= '0;
            cam_new_tag   <= '0;
            cam_new_valid <= 1'b0;
            cam_read      <= 1'b0;
            cam_check_tag <= '0;
`ifdef CAM_FILL_DUP_CHECK_EN
            r_tag         <= '0;
            r_data        <= '0;
`endif
        end else begin
            // Port outputs are strobes of the state being entered; park them by default.
            rsp_valid     <= 1'b0;
            rsp_status    <= ST_OK;
            rsp_addr      <= '0;
            cam_write_    <= 1'b1;
            cam_w_addr    <= '0;
            cam_wdata     <= '0;
            cam_new_tag   <= '0;
            cam_new_valid <= 1'b0;
            cam_read      <= 1'b0;
            cam_check_tag <= '0;

            case (r_state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_op == CAM_INVAL) begin
                            r_state    <= WRITE;
                            cam_write_ <= 1'b0;
                            cam_w_addr <= req_addr;
`ifdef CAM_FILL_DUP_CHECK_EN
                        end else begin
                            r_state       <= LOOKUP;
                            r_tag         <= req_tag;
                            r_data        <= req_data;
                            cam_read      <= 1'b1;
                            cam_check_tag <= req_tag;
                        end
`else
                        end else if (full) begin
                            r_state    <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_FULL;
                        end else begin
                            r_state       <= WRITE;
                            cam_write_    <= 1'b0;
                            cam_w_addr    <= w_free_idx;
                            cam_wdata     <= req_data;
                            cam_new_tag   <= req_tag;
                            cam_new_valid <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CAM_FILL_DUP_CHECK_EN
                LOOKUP: begin
                    if (cam_found_it) begin
                        r_state    <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_DUP;
                    end else if (full) begin
                        r_state    <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_FULL;
                    end else begin
                        r_state       <= WRITE;
                        cam_write_    <= 1'b0;
                        cam_w_addr    <= w_free_idx;
                        cam_wdata     <= r_data;
                        cam_new_tag   <= r_tag;
                        cam_new_valid <= 1'b1;
                    end
                end
`endif
                WRITE: begin
                    // Clearing an already-free slot leaves count alone.
                    if (cam_new_valid) begin
                        r_bitmap[cam_w_addr] <= 1'b1;
                        count                <= count + C_CNT_ONE;
                        full                 <= ((count + C_CNT_ONE) == C_CNT_FULL);
                    end else if (r_bitmap[cam_w_addr]) begin
                        r_bitmap[cam_w_addr] <= 1'b0;
                        count                <= count - C_CNT_ONE;
                        full                 <= 1'b0;
                    end
                    r_state    <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_status <= ST_OK;
                    rsp_addr   <= cam_w_addr;
                end
                RESP: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_fill_ctrl
// Brief    : Self-checking bench for cam_fill_ctrl with a behavioural CAM and
//            slot-allocation reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_fill_ctrl;

    localparam int BITS   = 8;
    localparam int TAG_SZ = 8;
    localparam int WORDS  = 8;
    localparam int AW     = $clog2(WORDS);
    localparam int CW     = $clog2(WORDS + 1);

`ifdef CAM_FILL_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_ = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_op = 1'b0;
    logic [TAG_SZ-1:0] req_tag = '0;
    logic [BITS-1:0]   req_data = '0;
    logic [AW-1:0]     req_addr = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [AW-1:0]     rsp_addr;
    logic              cam_write_;
    logic [AW-1:0]     cam_w_addr;
    logic [BITS-1:0]   cam_wdata;
    logic [TAG_SZ-1:0] cam_new_tag;
    logic              cam_new_valid;
    logic              cam_read;
    logic [TAG_SZ-1:0] cam_check_tag;
    logic              cam_found_it;
    logic              full;
    logic [CW-1:0]     count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_fill_ctrl #(
        .BITS   (BITS),
        .TAG_SZ (TAG_SZ),
        .WORDS  (WORDS)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_tag       (req_tag),
        .req_data      (req_data),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_status    (rsp_status),
        .rsp_addr      (rsp_addr),
        .cam_write_    (cam_write_),
        .cam_w_addr    (cam_w_addr),
        .cam_wdata     (cam_wdata),
        .cam_new_tag   (cam_new_tag),
        .cam_new_valid (cam_new_valid),
        .cam_read      (cam_read),
        .cam_check_tag (cam_check_tag),
        .cam_found_it  (cam_found_it),
        .full          (full),
        .count         (count)
    );

    // Behavioural cam2: stores whatever the write port commits, answers lookups combinationally.
    logic              cam_vld [WORDS];
    logic [TAG_SZ-1:0] cam_tag [WORDS];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < WORDS; i++) begin
                cam_vld[i] <= 1'b0;
                cam_tag[i] <= '0;
            end
        end else if (!cam_write_) begin
            cam_vld[cam_w_addr] <= cam_new_valid;
            cam_tag[cam_w_addr] <= cam_new_tag;
        end
    end

    always_comb begin
        cam_found_it = 1'b0;
        for (int i = 0; i < WORDS; i++)
            if (cam_read && cam_vld[i] && cam_tag[i] == cam_check_tag)
                cam_found_it = 1'b1;
    end

    // Reference model: which slots hold which tags.
    bit                mv   [WORDS];
    logic [TAG_SZ-1:0] mtag [WORDS];

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < WORDS; i++) n += int'(mv[i]);
        return n;
    endfunction

    function automatic int model_lowest_free();
        for (int i = 0; i < WORDS; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    function automatic bit model_has_tag(input logic [TAG_SZ-1:0] t);
        for (int i = 0; i < WORDS; i++) if (mv[i] && mtag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) begin
            mv[i]   = 1'b0;
            mtag[i] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        check("rst_ready",     32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_status",    32'(rsp_status), 0);
        check("rst_rsp_addr",  32'(rsp_addr), 0);
        check("rst_write_n",   32'(cam_write_), 1);
        check("rst_cam_outs",  32'({cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid}), 0);
        check("rst_cam_read",  32'({cam_read, cam_check_tag}), 0);
        check("rst_count",     32'(count), 0);
        check("rst_full",      32'(full), 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic do_req(input bit op, input logic [TAG_SZ-1:0] tag,
                          input logic [BITS-1:0] data, input logic [AW-1:0] addr);
        int e_st, e_addr, e_lat, e_wr, e_rd, e_wa, e_wv, e_wt, e_wd, e_ct, slot;
        int n_wr, n_rd, lat, rdy_low, wa, wv, wt, wd, ct, st, ra, cnt, fl, bad_idle;
        e_addr = 0; e_wr = 0; e_wa = 0; e_wv = 0; e_wt = 0; e_wd = 0; e_rd = 0;
        if (op == 1'b0) begin
            e_rd = DUP_EN ? 1 : 0;
            if (DUP_EN && model_has_tag(tag)) begin
                e_st = 1; e_lat = 2;
            end else if (model_count() == WORDS) begin
                e_st = 2; e_lat = DUP_EN ? 2 : 1;
            end else begin
                slot = model_lowest_free();
                e_st = 0; e_lat = DUP_EN ? 3 : 2; e_addr = slot;
                e_wr = 1; e_wa = slot; e_wv = 1; e_wt = int'(tag); e_wd = int'(data);
                mv[slot] = 1'b1; mtag[slot] = tag;
            end
        end else begin
            e_st = 0; e_lat = 2; e_addr = int'(addr);
            e_wr = 1; e_wa = int'(addr);
            mv[addr] = 1'b0;
        end
        e_ct = (e_rd != 0) ? int'(tag) : 0;

        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_op = op; req_tag = tag; req_data = data; req_addr = addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_tag = TAG_SZ'($urandom); req_data = BITS'($urandom); req_addr = AW'($urandom);

        n_wr = 0; n_rd = 0; lat = 0; rdy_low = 0; bad_idle = 0;
        wa = 0; wv = 0; wt = 0; wd = 0; ct = 0; st = -1; ra = -1; cnt = -1; fl = -1;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (!req_ready) rdy_low++;
            if (!cam_write_) begin
                n_wr++; wa = int'(cam_w_addr); wv = int'(cam_new_valid);
                wt = int'(cam_new_tag); wd = int'(cam_wdata);
            end else if ({cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid} != '0) begin
                bad_idle++;
            end
            if (cam_read) begin
                n_rd++; ct = int'(cam_check_tag);
            end else if (cam_check_tag != '0) begin
                bad_idle++;
            end
            if (rsp_valid) begin
                lat = k; st = int'(rsp_status); ra = int'(rsp_addr);
                cnt = int'(count); fl = int'(full);
            end
        end
        check("latency",     32'(lat), 32'(e_lat));
        check("ready_low",   32'(rdy_low), 32'(e_lat));
        check("rsp_status",  32'(st), 32'(e_st));
        check("rsp_addr",    32'(ra), 32'(e_addr));
        check("n_writes",    32'(n_wr), 32'(e_wr));
        check("w_addr",      32'(wa), 32'(e_wa));
        check("new_valid",   32'(wv), 32'(e_wv));
        check("new_tag",     32'(wt), 32'(e_wt));
        check("wdata",       32'(wd), 32'(e_wd));
        check("n_reads",     32'(n_rd), 32'(e_rd));
        check("check_tag",   32'(ct), 32'(e_ct));
        check("idle_outs",   32'(bad_idle), 0);
        check("count",       32'(cnt), 32'(model_count()));
        check("full",        32'(fl), 32'(model_count() == WORDS));
        @(negedge clk);
        check("rsp_one_shot", 32'(rsp_valid), 0);
        check("ready_back",   32'(req_ready), 1);
    endtask

    task automatic reset_mid_write(input logic [TAG_SZ-1:0] tag);
        int rsp_seen;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_tag = tag; req_data = 8'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 4 && cam_write_; i++) @(negedge clk);
        check("mid_write_seen", 32'(cam_write_), 0);
        #2;
        rst_ = 1'b0;
        #1;
        check("mid_rst_write_n", 32'(cam_write_), 1);
        check("mid_rst_cam",     32'({cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid}), 0);
        check("mid_rst_ready",   32'(req_ready), 0);
        check("mid_rst_rsp",     32'(rsp_valid), 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("mid_no_rsp", 32'(rsp_seen), 0);
        check("mid_count",  32'(count), 0);
    endtask

    initial begin
        model_clear();
        #3;
        rst_ = 1'b0;
        #20;
        rst_ = 1'b1;

        do_reset();
        do_req(1'b0, 8'h05, 8'h11, '0);

        do_reset();
        for (int t = 1; t <= 8; t++) do_req(1'b0, TAG_SZ'(t), BITS'(8'hA0 + t), '0);
        check("filled_full", 32'(full), 1);
        do_req(1'b0, 8'h09, 8'h99, '0);

        do_req(1'b1, '0, '0, AW'(3));
        do_req(1'b0, 8'h0A, 8'h3C, '0);

        do_req(1'b1, '0, '0, AW'(0));
        do_req(1'b0, 8'h06, 8'h66, '0);
        do_req(1'b0, 8'h06, 8'h67, '0);

        do_req(1'b1, '0, '0, AW'(5));
        do_req(1'b1, '0, '0, AW'(5));

        do_reset();
        reset_mid_write(8'h42);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_req(1'b1, '0, '0, AW'($urandom_range(0, WORDS - 1)));
            else
                do_req(1'b0, TAG_SZ'($urandom_range(1, 12)), BITS'($urandom), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
